// File: rtl/k12_alu_seq.sv
// k12_alu_seq: clocked K12 execute-stage ALU with a registered flag file,
// carry-chained arithmetic, serial multi-bit shifts and an optional
// shift-add multiplier behind a start/busy/done handshake.
// Optional feature: define K12_ALU_MUL_EN to build the multiplier (ops 12/13);
// without it those ops complete in one cycle as PASS.
module k12_alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic             imm_sel,
  input  logic [2:0]       cond_sel,
  input  logic             cond_inv,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             cond
);

  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_ASR1 = 4'd6;
  localparam logic [3:0] OP_MOVB = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBB  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_MULH = 4'd13;

`ifdef K12_ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] bi, bi_q, acc, hi;
  logic [SHW:0]     cnt;
  logic             accept, is_shift, is_mul, multi, last;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] s_res;
  logic             s_c, s_v;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_acc, step_hi, step_res;
  logic             step_c;
  logic             sel_c;

  assign bi       = imm_sel ? imm : b;
  assign accept   = start && (state != RUN);
  assign is_shift = (op == OP_SHL) || (op == OP_SHR);
  assign is_mul   = MUL_EN && ((op == OP_MUL) || (op == OP_MULH));
  // A zero shift count has nothing to iterate, so it finishes like a PASS.
  assign multi    = (is_shift && (bi[SHW-1:0] != '0)) || is_mul;
  assign last     = (cnt == (SHW+1)'(1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // Adder operand and carry-in selection shared by ADD/SUB/ADC/SBB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    add_y   = bi;
    add_cin = 1'b0;
    case (op)
      OP_SUB:  begin add_y = ~bi; add_cin = 1'b1;   end
      OP_ADC:  add_cin = flag_c;
      OP_SBB:  begin add_y = ~bi; add_cin = flag_c; end
      default: ;
    endcase
    add_sum = {1'b0, a} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  end

  // Single-cycle result and C/V values; C and V default to their held values.
  always_comb begin
    s_res = a;
    s_c   = flag_c;
    s_v   = flag_v;
    case (op)
      OP_AND:  s_res = a & bi;
      OP_OR:   s_res = a | bi;
      OP_XOR:  s_res = a ^ bi;
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
        s_res = add_sum[WIDTH-1:0];
        s_c   = add_sum[WIDTH];
        s_v   = (a[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ASR1: begin
        s_res = {a[WIDTH-1], a[WIDTH-1:1]};
        s_c   = a[0];
      end
      OP_MOVB: s_res = bi;
      default: s_res = a;  // PASS, reserved, zero-count shift, MUL without multiplier
    endcase
  end

  // One iteration of the serial shifter or the shift-add multiplier.
  always_comb begin
    mul_sum  = {1'b0, hi} + (acc[0] ? {1'b0, bi_q} : '0);
    step_acc = acc;
    step_hi  = hi;
    step_c   = flag_c;
    case (op_q)
      OP_SHL: begin
        step_acc = {acc[WIDTH-2:0], 1'b0};
        step_c   = acc[WIDTH-1];
      end
      OP_SHR: begin
        step_acc = {1'b0, acc[WIDTH-1:1]};
        step_c   = acc[0];
      end
      OP_MUL, OP_MULH: begin
        step_acc = {mul_sum[0], acc[WIDTH-1:1]};
        step_hi  = mul_sum[WIDTH:1];
      end
      default: ;
    endcase
    step_res = (op_q == OP_MULH) ? step_hi : step_acc;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic: accept in IDLE/DONE, iterate in RUN until the count is spent.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (last) state_nx = DONE;
      default: begin
        if (accept) state_nx = multi ? RUN : DONE;
        else        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, iterate in RUN, write result and flags on completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: working registers are reset too; the abort path must not leave a half-finished operation behind.
      res    <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      op_q   <= '0;
      bi_q   <= '0;
      acc    <= '0;
      hi     <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc <= step_acc;
      hi  <= step_hi;
      cnt <= cnt - (SHW+1)'(1);
      if (last) begin
        res    <= step_res;
        flag_z <= (step_res == '0);
        flag_n <= step_res[WIDTH-1];
        flag_c <= step_c;
      end
    end else if (accept) begin
      op_q <= op;
      bi_q <= bi;
      acc  <= a;
      hi   <= '0;
      cnt  <= is_mul ? (SHW+1)'(WIDTH) : {1'b0, bi[SHW-1:0]};
      if (!multi) begin
        res    <= s_res;
        flag_z <= (s_res == '0);
        flag_n <= s_res[WIDTH-1];
        flag_c <= s_c;
        flag_v <= s_v;
      end
    end
  end

  // Condition decode from the registered flags.
  always_comb begin
    sel_c = flag_z;
    case (cond_sel)
      3'd0: sel_c = flag_z;
      3'd1: sel_c = flag_n;
      3'd2: sel_c = ~flag_c;
      3'd3: sel_c = flag_v;
      3'd4: sel_c = flag_c;
      3'd5: sel_c = ~flag_c | flag_z;
      3'd6: sel_c = flag_n ^ flag_v;
      3'd7: sel_c = (flag_n ^ flag_v) | flag_z;
      default: ;
    endcase
  end

  assign cond = sel_c ^ cond_inv;

endmodule
